store_split_align: RTL and testbench

Registered, parametrised store-alignment stage between the LSU address/data path and the data-cache write port. It takes one store request (address, `mem_access_size_t` size, XLEN data) per valid/ready handshake and emits bus-aligned write beats with per-byte masks. Stores that cross a bus-word boundary are split into two beats when misaligned support is enabled; otherwise they raise an alignment fault. Output is registered, with backpressure.

---
 rtl/store_split_align.sv | 137 +++++++++++++
 tb/tb_store_split_align.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_split_align.sv
// Store alignment stage: turns one LSU store into one or two bus-aligned write beats with
// byte masks, registered output with valid/ready backpressure.
package store_split_align_pkg;
  typedef enum logic [2:0] {
    BYTE        = 3'd0,
    HALF_WORD   = 3'd1,
    WORD        = 3'd2,
    DOUBLE_WORD = 3'd3
  } mem_access_size_t;
endpackage

module store_split_align
  import store_split_align_pkg::*;
#(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned BUS_BYTES   = 8,
  parameter bit          MISALIGN_EN = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [63:0]            req_addr_i,
  input  mem_access_size_t       req_size_i,
  input  logic [XLEN-1:0]        req_data_i,
  output logic                   beat_valid_o,
  input  logic                   beat_ready_i,
  output logic [63:0]            beat_addr_o,
  output logic [8*BUS_BYTES-1:0] beat_data_o,
  output logic [BUS_BYTES-1:0]   beat_mask_o,
  output logic                   beat_last_o,
  output logic                   beat_err_o
);

  localparam int unsigned OffW = $clog2(BUS_BYTES);
  localparam int unsigned BusW = 8 * BUS_BYTES;
  localparam int unsigned ExtW = (XLEN > BusW) ? XLEN : BusW;

  typedef enum logic [1:0] {StEmpty, StLast, StFirst} state_e;

  state_e                 state_q;
  logic [63:0]            pend_addr_q;
  logic [BusW-1:0]        pend_data_q;
  logic [BUS_BYTES-1:0]   pend_mask_q;

  int unsigned            n_bytes;
  logic                   size_ok;
  logic                   misaligned;
  logic                   crossing;
  logic                   fault;
  logic                   accept;
  logic [OffW-1:0]        offset;
  logic [63:0]            aligned_addr;
  logic [ExtW-1:0]        data_ext;
  logic [BusW-1:0]        data_lo;
  logic [BUS_BYTES-1:0]   byte_en;
  logic [2*BusW-1:0]      shift_data;
  logic [2*BUS_BYTES-1:0] shift_mask;

  assign beat_valid_o = (state_q != StEmpty);
  // Ready depends only on state and downstream ready, never on req_valid_i.
  assign req_ready_o  = (state_q == StEmpty) || ((state_q == StLast) && beat_ready_i);
  assign accept       = req_valid_i && req_ready_o;

  always_comb begin
    size_ok = 1'b1;
    case (req_size_i)
      BYTE:        n_bytes = 1;
      HALF_WORD:   n_bytes = 2;
      WORD:        n_bytes = 4;
      DOUBLE_WORD: n_bytes = 8;
      default: begin
        n_bytes = 1;
        size_ok = 1'b0;
      end
    endcase
    offset       = req_addr_i[OffW-1:0];
    aligned_addr = req_addr_i & ~64'(BUS_BYTES - 1);
    misaligned   = (req_addr_i[2:0] & 3'(n_bytes - 1)) != 3'd0;
    crossing     = (32'(offset) + n_bytes) > BUS_BYTES;
    fault        = !size_ok || (n_bytes > BUS_BYTES) || (n_bytes * 8 > XLEN) ||
                   (!MISALIGN_EN && misaligned);
    data_ext     = ExtW'(req_data_i);
    for (int i = 0; i < BUS_BYTES; i++) begin
      byte_en[i]        = unsigned'(i) < n_bytes;
      data_lo[8*i +: 8] = byte_en[i] ? data_ext[8*i +: 8] : 8'h00;
    end
    shift_data = {{BusW{1'b0}}, data_lo} << {offset, 3'b000};
    shift_mask = {{BUS_BYTES{1'b0}}, byte_en} << offset;
  end

  // Accept is only possible from StEmpty or from StLast while its beat drains,
  // so a new load always takes priority over the drain transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StEmpty;
      beat_addr_o <= '0;
      beat_data_o <= '0;
      beat_mask_o <= '0;
      beat_last_o <= 1'b0;
      beat_err_o  <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      pend_mask_q <= '0;
    end else if (accept) begin
      beat_addr_o <= aligned_addr;
      if (fault) begin
        beat_data_o <= '0;
        beat_mask_o <= '0;
        beat_last_o <= 1'b1;
        beat_err_o  <= 1'b1;
        state_q     <= StLast;
      end else begin
        beat_data_o <= shift_data[BusW-1:0];
        beat_mask_o <= shift_mask[BUS_BYTES-1:0];
        beat_last_o <= !crossing;
        beat_err_o  <= 1'b0;
        pend_addr_q <= aligned_addr + 64'(BUS_BYTES);
        pend_data_q <= shift_data[2*BusW-1:BusW];
        pend_mask_q <= shift_mask[2*BUS_BYTES-1:BUS_BYTES];
        state_q     <= crossing ? StFirst : StLast;
      end
    end else if (beat_valid_o && beat_ready_i) begin
      if (state_q == StFirst) begin
        beat_addr_o <= pend_addr_q;
        beat_data_o <= pend_data_q;
        beat_mask_o <= pend_mask_q;
        beat_last_o <= 1'b1;
        beat_err_o  <= 1'b0;
        state_q     <= StLast;
      end else begin
        state_q <= StEmpty;
      end
    end
  end

endmodule

// File: tb/tb_store_split_align.sv
// Directed bench for store_split_align: three instances cover split-enabled, split-disabled
// and 4-byte-bus configurations.
module tb_store_split_align;
  import store_split_align_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [63:0]      req_addr = '0;
  mem_access_size_t req_size = BYTE;
  logic [63:0]      req_data = '0;
  logic             beat_ready = 1'b1;
  logic             valid_a = 1'b0, valid_n = 1'b0, valid_b = 1'b0;

  logic rdy_a, bv_a, blast_a, berr_a;
  logic [63:0] baddr_a, bdata_a;
  logic [7:0] bmask_a;
  logic rdy_n, bv_n, blast_n, berr_n;
  logic [63:0] baddr_n, bdata_n;
  logic [7:0] bmask_n;
  logic rdy_b, bv_b, blast_b, berr_b;
  logic [63:0] baddr_b;
  logic [31:0] bdata_b;
  logic [3:0] bmask_b;

  int vectors = 0;
  int errors = 0;

  store_split_align #(.XLEN(64), .BUS_BYTES(8), .MISALIGN_EN(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .req_valid_i(valid_a), .req_ready_o(rdy_a), .req_addr_i(req_addr),
    .req_size_i(req_size), .req_data_i(req_data), .beat_valid_o(bv_a),
    .beat_ready_i(beat_ready), .beat_addr_o(baddr_a), .beat_data_o(bdata_a),
    .beat_mask_o(bmask_a), .beat_last_o(blast_a), .beat_err_o(berr_a)
  );

  store_split_align #(.XLEN(64), .BUS_BYTES(8), .MISALIGN_EN(1'b0)) u_dut_n (
    .clk(clk), .rst(rst), .req_valid_i(valid_n), .req_ready_o(rdy_n), .req_addr_i(req_addr),
    .req_size_i(req_size), .req_data_i(req_data), .beat_valid_o(bv_n),
    .beat_ready_i(beat_ready), .beat_addr_o(baddr_n), .beat_data_o(bdata_n),
    .beat_mask_o(bmask_n), .beat_last_o(blast_n), .beat_err_o(berr_n)
  );

  store_split_align #(.XLEN(64), .BUS_BYTES(4), .MISALIGN_EN(1'b1)) u_dut_b (
    .clk(clk), .rst(rst), .req_valid_i(valid_b), .req_ready_o(rdy_b), .req_addr_i(req_addr),
    .req_size_i(req_size), .req_data_i(req_data), .beat_valid_o(bv_b),
    .beat_ready_i(beat_ready), .beat_addr_o(baddr_b), .beat_data_o(bdata_b),
    .beat_mask_o(bmask_b), .beat_last_o(blast_b), .beat_err_o(berr_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    beat_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    vectors++;
    if ({bv_a, blast_a, berr_a} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b expected 000", {bv_a, blast_a, berr_a});
    end
    vectors++;
    if ({baddr_a, bdata_a, bmask_a} !== '0) begin
      errors++; $display("FAIL reset_data: got %h %h %h expected zeros", baddr_a, bdata_a, bmask_a);
    end
    vectors++;
    if ({rdy_a, rdy_n, rdy_b} !== 3'b111) begin
      errors++; $display("FAIL reset_ready: got %b expected 111", {rdy_a, rdy_n, rdy_b});
    end
  endtask

  task automatic test_aligned_word();
    req_addr = 64'h1004; req_size = WORD; req_data = 64'h1122_3344_AABB_CCDD;
    beat_ready = 1'b1; valid_a = 1'b1;
    step();
    valid_a = 1'b0;
    vectors++;
    if ({bv_a, blast_a, berr_a} !== 3'b110) begin
      errors++; $display("FAIL sw_flags: got %b expected 110", {bv_a, blast_a, berr_a});
    end
    vectors++;
    if (baddr_a !== 64'h1000 || bmask_a !== 8'hF0) begin
      errors++; $display("FAIL sw_addr_mask: got %h %h expected 1000 f0", baddr_a, bmask_a);
    end
    vectors++;
    if (bdata_a !== 64'hAABB_CCDD_0000_0000) begin
      errors++; $display("FAIL sw_data: got %h expected aabbccdd00000000", bdata_a);
    end
    step();
    vectors++;
    if (bv_a !== 1'b0) begin
      errors++; $display("FAIL sw_drain: got %b expected 0", bv_a);
    end
  endtask

  task automatic test_split();
    req_addr = 64'h1006; req_size = WORD; req_data = 64'hAABB_CCDD;
    beat_ready = 1'b0; valid_a = 1'b1;
    step();
    valid_a = 1'b0;
    vectors++;
    if ({bv_a, blast_a, berr_a, rdy_a} !== 4'b1000) begin
      errors++; $display("FAIL split_b0_flags: got %b expected 1000", {bv_a, blast_a, berr_a, rdy_a});
    end
    vectors++;
    if (baddr_a !== 64'h1000 || bmask_a !== 8'hC0 || bdata_a !== 64'hCCDD_0000_0000_0000) begin
      errors++; $display("FAIL split_b0: got %h %h %h expected 1000 c0 ccdd000000000000",
                         baddr_a, bmask_a, bdata_a);
    end
    beat_ready = 1'b1;
    #1;
    vectors++;
    if (rdy_a !== 1'b0) begin
      errors++; $display("FAIL split_ready_first: got %b expected 0", rdy_a);
    end
    step();
    vectors++;
    if ({bv_a, blast_a, berr_a} !== 3'b110) begin
      errors++; $display("FAIL split_b1_flags: got %b expected 110", {bv_a, blast_a, berr_a});
    end
    vectors++;
    if (baddr_a !== 64'h1008 || bmask_a !== 8'h03 || bdata_a !== 64'hAABB) begin
      errors++; $display("FAIL split_b1: got %h %h %h expected 1008 03 aabb",
                         baddr_a, bmask_a, bdata_a);
    end
    step();
    vectors++;
    if (bv_a !== 1'b0) begin
      errors++; $display("FAIL split_drain: got %b expected 0", bv_a);
    end
  endtask

  task automatic test_faults();
    // Same misaligned halfword: split-enabled instance stores it, the other faults.
    req_addr = 64'h2001; req_size = HALF_WORD; req_data = 64'h1234;
    beat_ready = 1'b1; valid_a = 1'b1; valid_n = 1'b1;
    step();
    valid_a = 1'b0; valid_n = 1'b0;
    vectors++;
    if ({bv_n, blast_n, berr_n} !== 3'b111 || bmask_n !== 8'h00 || bdata_n !== 64'h0 ||
        baddr_n !== 64'h2000) begin
      errors++; $display("FAIL sh_fault: got %b %h %h %h expected 111 00 0 2000",
                         {bv_n, blast_n, berr_n}, bmask_n, bdata_n, baddr_n);
    end
    vectors++;
    if ({bv_a, blast_a, berr_a} !== 3'b110 || bmask_a !== 8'h06 || bdata_a !== 64'h12_3400) begin
      errors++; $display("FAIL sh_inword: got %b %h %h expected 110 06 123400",
                         {bv_a, blast_a, berr_a}, bmask_a, bdata_a);
    end
    req_addr = 64'h4003; req_size = mem_access_size_t'(3'd5); valid_a = 1'b1;
    step();
    valid_a = 1'b0;
    vectors++;
    if ({bv_a, blast_a, berr_a} !== 3'b111 || bmask_a !== 8'h00 || baddr_a !== 64'h4000) begin
      errors++; $display("FAIL bad_size: got %b %h %h expected 111 00 4000",
                         {bv_a, blast_a, berr_a}, bmask_a, baddr_a);
    end
    step();
    vectors++;
    if ({bv_a, bv_n} !== 2'b00) begin
      errors++; $display("FAIL fault_drain: got %b expected 00", {bv_a, bv_n});
    end
  endtask

  task automatic test_hold();
    req_addr = 64'h3000; req_size = DOUBLE_WORD; req_data = 64'h0123_4567_89AB_CDEF;
    beat_ready = 1'b0; valid_b = 1'b1;
    step();
    valid_b = 1'b0;
    for (int c = 0; c < 5; c++) begin
      vectors++;
      if ({bv_b, blast_b, berr_b, rdy_b} !== 4'b1110 || bmask_b !== 4'h0 ||
          bdata_b !== 32'h0 || baddr_b !== 64'h3000) begin
        errors++; $display("FAIL sd_hold%0d: got %b %h %h %h expected 1110 0 0 3000",
                           c, {bv_b, blast_b, berr_b, rdy_b}, bmask_b, bdata_b, baddr_b);
      end
      step();
    end
    beat_ready = 1'b1;
    #1;
    vectors++;
    if (rdy_b !== 1'b1) begin
      errors++; $display("FAIL sd_ready_comb: got %b expected 1", rdy_b);
    end
    step();
    vectors++;
    if ({bv_b, rdy_b} !== 2'b01) begin
      errors++; $display("FAIL sd_done: got %b expected 01", {bv_b, rdy_b});
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_data;
    beat_ready = 1'b1; req_size = BYTE;
    for (int i = 0; i < 8; i++) begin
      req_addr = 64'h10 + 64'(i);
      req_data = 64'(8'hA0 + i);
      valid_a = 1'b1;
      #1;
      vectors++;
      if (rdy_a !== 1'b1) begin
        errors++; $display("FAIL b2b_ready%0d: got %b expected 1", i, rdy_a);
      end
      step();
      exp_data = 64'(8'hA0 + i) << (8 * i);
      vectors++;
      if ({bv_a, blast_a, berr_a} !== 3'b110 || baddr_a !== 64'h10 ||
          bmask_a !== 8'(1 << i) || bdata_a !== exp_data) begin
        errors++; $display("FAIL b2b_beat%0d: got %b %h %h %h expected 110 10 %h %h", i,
                           {bv_a, blast_a, berr_a}, baddr_a, bmask_a, bdata_a,
                           8'(1 << i), exp_data);
      end
    end
    valid_a = 1'b0;
    step();
    vectors++;
    if (bv_a !== 1'b0) begin
      errors++; $display("FAIL b2b_drain: got %b expected 0", bv_a);
    end
  endtask

  task automatic test_reset_mid_split();
    req_addr = 64'h1006; req_size = WORD; req_data = 64'hAABB_CCDD;
    beat_ready = 1'b0; valid_a = 1'b1;
    step();
    valid_a = 1'b0;
    vectors++;
    if ({bv_a, blast_a} !== 2'b10) begin
      errors++; $display("FAIL rst_split_pre: got %b expected 10", {bv_a, blast_a});
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if ({bv_a, rdy_a} !== 2'b01 || bmask_a !== 8'h00) begin
      errors++; $display("FAIL rst_split_post: got %b %h expected 01 00", {bv_a, rdy_a}, bmask_a);
    end
    beat_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      vectors++;
      if (bv_a !== 1'b0) begin
        errors++; $display("FAIL rst_split_no_b1_%0d: got %b expected 0", c, bv_a);
      end
    end
  endtask

  initial begin
    test_reset();
    test_aligned_word();
    test_split();
    test_faults();
    test_hold();
    test_back_to_back();
    test_reset_mid_split();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
